alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL provide parameter SERIAL_SHIFT, default 1: 1 = shifts executed one bit per cycle; 0 = shifts complete in a single cycle like other ops.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request holds valid operation.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port alu_control  input  4  operation code from the decode unit.
REQ-007 SHALL have port op_a  input  32  first operand / shift source.
REQ-008 SHALL have port op_b  input  32  second operand; op_b[4:0] is shift amount.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  32  operation result.
REQ-012 SHALL have port zero  output  1  high when result == 0.
REQ-013 SHALL have port illegal  output  1  high when the completed op had an undefined code.

Function
REQ-014 SHALL decode alu_control: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 SLTU, 0111 XOR, 1000 SLT, 1001 SRA; all other codes (incl. 1111) illegal.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where in_valid && in_ready, capturing alu_control, op_a, op_b; later input changes have no effect on that operation.
REQ-017 Non-shift, illegal, and zero-amount shift ops (and all shifts when SERIAL_SHIFT=0): SHALL register result at the accept edge, enter DONE, out_valid high in the following cycle (latency 1).
REQ-018 Shift with shamt k > 0 and SERIAL_SHIFT=1: SHALL enter SHIFT with count=k, shift working value by one bit and decrement count per edge; on the edge where count reaches 0, enter DONE (out_valid visible k+1 edges after accept, inclusive).
REQ-019 ADD/SUB SHALL wrap modulo 2^32; no overflow flag.
REQ-020 SLT SHALL compare signed, SLTU unsigned; result 32'h1 or 32'h0.
REQ-021 SLL/SRL SHALL fill with zeros; SRA SHALL replicate op_a[31].
REQ-022 Illegal op SHALL produce result 0, zero 1, illegal 1; legal ops illegal 0.
REQ-023 In DONE, result/zero/illegal/out_valid SHALL remain stable until out_ready is sampled high; then return to IDLE with out_valid low next cycle.
REQ-024 SHALL NOT accept a new request in the same cycle a result is consumed (in_ready low in DONE); max throughput one op per 2 cycles.
REQ-025 out_ready while out_valid low SHALL be ignored; in_valid outside IDLE SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready 1 after release, out_valid 0, result 0, zero 0, illegal 0, shift count 0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result delivered after release.
REQ-028 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 ADD 32'hFFFF_FFFF + 32'h1, out_ready=1 -> out_valid one cycle after accept, result 0, zero 1, illegal 0.
REQ-030 SLT op_a=32'hFFFF_FFFE, op_b=1 -> result 1; SLTU same operands -> result 0.
REQ-031 SRA op_a=32'h8000_0000, op_b=31, SERIAL_SHIFT=1 -> in_ready low 31 cycles, result 32'hFFFF_FFFF at edge 32 after accept; SRL same -> 32'h1.
REQ-032 alu_control=1111 -> result 0, zero 1, illegal 1, latency 1.
REQ-033 out_ready held low 5 cycles after SUB 10-3 -> result 7 and out_valid stable all 5 cycles; in_ready low until cycle after handshake.
REQ-034 rst_n pulsed low during SLL shamt=20 at cycle 8 -> outputs 0 immediately, no out_valid after release, new ADD accepted on next edge.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle 32-bit ALU with a valid/ready request side and a held result side.
// Shifts can run one bit per cycle (SERIAL_SHIFT=1) or finish in one cycle like the other ops.
module alu_multicycle #(
    parameter int SERIAL_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_control,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0, OP_OR  = 4'h1, OP_ADD  = 4'h2, OP_SLL = 4'h3, OP_SUB = 4'h4,
        OP_SRL  = 4'h5, OP_SLTU = 4'h6, OP_XOR = 4'h7, OP_SLT = 4'h8, OP_SRA = 4'h9
    } op_e;

    state_e      r_state;
    logic [3:0]  r_op;
    logic [31:0] r_work;
    logic [4:0]  r_count;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;

    logic [31:0] w_alu;
    logic        w_illegal;
    logic [4:0]  w_shamt;
    logic        w_is_shift;
    logic        w_go_serial;
    logic [31:0] w_step;

    always_comb begin
        w_shamt   = op_b[4:0];
        w_alu     = '0;
        w_illegal = 1'b0;
        case (alu_control)
            OP_AND:  w_alu = op_a & op_b;
            OP_OR:   w_alu = op_a | op_b;
            OP_ADD:  w_alu = op_a + op_b;
            OP_SLL:  w_alu = op_a << w_shamt;
            OP_SUB:  w_alu = op_a - op_b;
            OP_SRL:  w_alu = op_a >> w_shamt;
            OP_SLTU: w_alu = {31'b0, op_a < op_b};
            OP_XOR:  w_alu = op_a ^ op_b;
            OP_SLT:  w_alu = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
            default: w_illegal = 1'b1;
        endcase
        w_is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL) || (alu_control == OP_SRA);
        // Zero-amount shifts take the single-cycle path so count never starts at 0.
        w_go_serial = (SERIAL_SHIFT != 0) && w_is_shift && (w_shamt != 5'd0);
    end

    always_comb begin
        case (r_op)
            OP_SLL:  w_step = {r_work[30:0], 1'b0};
            OP_SRA:  w_step = {r_work[31], r_work[31:1]};
            default: w_step = {1'b0, r_work[31:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_work    <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_go_serial) begin
                            r_op    <= alu_control;
                            r_work  <= op_a;
                            r_count <= w_shamt;
                            r_state <= S_SHIFT;
                        end else begin
                            r_result  <= w_alu;
                            r_zero    <= (w_alu == '0);
                            r_illegal <= w_illegal;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_step;
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_result  <= w_step;
                        r_zero    <= (w_step == '0);
                        r_illegal <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations queued at accept, compared on out_valid.
module tb_alu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        il;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_multicycle #(.SERIAL_SHIFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        logic [4:0] sh;
        sh   = b[4:0];
        e.il = 1'b0;
        e.r  = 32'h0;
        case (c)
            4'h0: e.r = a & b;
            4'h1: e.r = a | b;
            4'h2: e.r = a + b;
            4'h3: e.r = a << sh;
            4'h4: e.r = a - b;
            4'h5: e.r = a >> sh;
            4'h6: e.r = (a < b) ? 32'h1 : 32'h0;
            4'h7: e.r = a ^ b;
            4'h8: e.r = (a[31] != b[31]) ? {31'b0, a[31]} : ((a < b) ? 32'h1 : 32'h0);
            4'h9: e.r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default: e.il = 1'b1;
        endcase
        e.z   = (e.r == 32'h0);
        e.lat = ((c == 4'h3 || c == 4'h5 || c == 4'h9) && sh != 5'd0) ? int'(sh) + 1 : 1;
        return e;
    endfunction

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid    = 1'b1;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        sb.push_back(model(c, a, b));
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        op_a        = $urandom;
        op_b        = $urandom;
    endtask

    // Waits (bounded) for out_valid; lat counts negedges after the accept edge, rdy counts in_ready highs seen meanwhile.
    task automatic collect(output logic [31:0] r, output logic z, output logic il, output int lat, output int rdy);
        bit got;
        got = 1'b0;
        lat = -1;
        rdy = 0;
        r   = 'x;
        z   = 1'bx;
        il  = 1'bx;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                lat = n;
                r   = result;
                z   = zero;
                il  = illegal;
            end else if (in_ready === 1'b1) begin
                rdy++;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        #7;
        checks++;
        if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b il=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, zero, illegal);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        in_valid    = 1'b1;
        alu_control = 4'h2;
        op_a        = 32'd5;
        op_b        = 32'd6;
        sb.push_back(model(4'h2, 32'd5, 32'd6));
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_accept_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(r, z, il, lat, rdy);
        e = sb.pop_front();
        checks++;
        if ({r, z, il} !== {e.r, e.z, e.il} || lat !== e.lat) begin
            errors++;
            $display("FAIL first_add got %h/%b/%b lat %0d want %h/%b/%b lat %0d", r, z, il, lat, e.r, e.z, e.il, e.lat);
        end
    endtask

    task automatic test_add_wrap;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        send(4'h2, 32'hFFFF_FFFF, 32'h1);
        collect(r, z, il, lat, rdy);
        e = sb.pop_front();
        checks++;
        if ({r, z, il} !== {32'h0, 1'b1, 1'b0} || {r, z, il} !== {e.r, e.z, e.il}) begin
            errors++;
            $display("FAIL add_wrap got %h/%b/%b want 00000000/1/0", r, z, il);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL add_wrap_latency got %0d want 1", lat);
        end
    endtask

    task automatic test_slt;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        logic [3:0]  codes [2];
        codes[0] = 4'h8;
        codes[1] = 4'h6;
        for (int i = 0; i < 2; i++) begin
            send(codes[i], 32'hFFFF_FFFE, 32'h1);
            collect(r, z, il, lat, rdy);
            e = sb.pop_front();
            checks++;
            if ({r, z, il} !== {e.r, e.z, e.il} || lat !== e.lat) begin
                errors++;
                $display("FAIL slt_code%h got %h/%b/%b lat %0d want %h/%b/%b lat %0d",
                         codes[i], r, z, il, lat, e.r, e.z, e.il, e.lat);
            end
        end
    endtask

    task automatic test_shift;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        logic [3:0]  codes [3];
        logic [31:0] as [3];
        logic [31:0] bs [3];
        codes[0] = 4'h9; as[0] = 32'h8000_0000; bs[0] = 32'd31;
        codes[1] = 4'h5; as[1] = 32'h8000_0000; bs[1] = 32'd31;
        codes[2] = 4'h3; as[2] = 32'h0000_1234; bs[2] = 32'h20;
        for (int i = 0; i < 3; i++) begin
            send(codes[i], as[i], bs[i]);
            collect(r, z, il, lat, rdy);
            e = sb.pop_front();
            checks++;
            if ({r, z, il} !== {e.r, e.z, e.il}) begin
                errors++;
                $display("FAIL shift%0d_result got %h/%b/%b want %h/%b/%b", i, r, z, il, e.r, e.z, e.il);
            end
            checks++;
            if (lat !== e.lat || rdy !== 0) begin
                errors++;
                $display("FAIL shift%0d_timing got lat %0d ready_highs %0d want lat %0d ready_highs 0", i, lat, rdy, e.lat);
            end
        end
    endtask

    task automatic test_illegal;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        logic [3:0]  codes [2];
        codes[0] = 4'hF;
        codes[1] = 4'hA;
        for (int i = 0; i < 2; i++) begin
            send(codes[i], $urandom, $urandom);
            collect(r, z, il, lat, rdy);
            e = sb.pop_front();
            checks++;
            if ({r, z, il} !== {32'h0, 1'b1, 1'b1} || lat !== 1) begin
                errors++;
                $display("FAIL illegal_code%h got %h/%b/%b lat %0d want 00000000/1/1 lat 1", codes[i], r, z, il, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        send(4'h4, 32'd10, 32'd3);
        out_ready = 1'b0;
        collect(r, z, il, lat, rdy);
        e = sb.pop_front();
        checks++;
        if ({r, z, il} !== {e.r, e.z, e.il} || lat !== 1) begin
            errors++;
            $display("FAIL sub_result got %h/%b/%b lat %0d want %h/%b/%b lat 1", r, z, il, lat, e.r, e.z, e.il);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result, zero, illegal} !== {1'b1, 1'b0, 32'd7, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=00000007",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_handshake got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        send(4'h3, 32'h1, 32'd20);
        e = sb.pop_back();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, result, zero, illegal} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got vld=%b rdy=%b res=%h z=%b il=%b want 0 1 0 0 0",
                     out_valid, in_ready, result, zero, illegal);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        in_valid    = 1'b1;
        alu_control = 4'h2;
        op_a        = 32'h100;
        op_b        = 32'h23;
        sb.push_back(model(4'h2, 32'h100, 32'h23));
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(r, z, il, lat, rdy);
        e = sb.pop_front();
        checks++;
        if ({r, z, il} !== {e.r, e.z, e.il} || lat !== 1) begin
            errors++;
            $display("FAIL post_reset_add got %h/%b/%b lat %0d want %h/%b/%b lat 1", r, z, il, lat, e.r, e.z, e.il);
        end
    endtask

    task automatic test_ignore;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        int          extra;
        exp_t        e;
        send(4'h5, 32'hF0, 32'd4);
        in_valid    = 1'b1;
        alu_control = 4'h2;
        op_a        = 32'h1;
        op_b        = 32'h1;
        collect(r, z, il, lat, rdy);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({r, z, il} !== {32'hF, 1'b0, 1'b0} || lat !== e.lat || rdy !== 0) begin
            errors++;
            $display("FAIL ignore_busy got %h/%b/%b lat %0d rdy %0d want 0000000f/0/0 lat %0d rdy 0",
                     r, z, il, lat, rdy, e.lat);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_no_extra got %0d valid cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        z, il;
        int          lat, rdy;
        exp_t        e;
        logic [3:0]  c;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            send(c, $urandom, $urandom);
            collect(r, z, il, lat, rdy);
            e = sb.pop_front();
            checks++;
            if ({r, z, il} !== {e.r, e.z, e.il} || lat !== e.lat) begin
                errors++;
                $display("FAIL rand%0d_op%h got %h/%b/%b lat %0d want %h/%b/%b lat %0d",
                         i, c, r, z, il, lat, e.r, e.z, e.il, e.lat);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = '0;
        op_a        = '0;
        op_b        = '0;
        test_reset;
        test_add_wrap;
        test_slt;
        test_shift;
        test_illegal;
        test_backpressure;
        test_reset_mid_shift;
        test_ignore;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
